// File: rtl/aes128_cbc_seq.sv
`default_nettype none
// ============================================================================
//  Module      : aes128_cbc_seq
//  Description : Block sequencer that wraps an existing AES-128 core and
//                adds CBC chaining. One block is in flight at a time:
//                IDLE accepts a block, ISSUE starts the core, WAIT collects
//                the core result, OUT holds the ciphertext until the sink
//                accepts it.
//
//  Configuration macro:
//    AES_CBC_CHAIN_EN  defined   -> CBC mode (XOR with chain, IV register)
//                      undefined -> ECB mode (no XOR, no chain/IV registers,
//                                   iv_i / iv_load_i ignored)
//
//  Ports:
//    clk, rst              clock, synchronous active-high reset
//    key_i                 cipher key, captured when a block is accepted
//    iv_i, iv_load_i       IV value and load pulse (honoured only in IDLE)
//    in_valid_i/in_ready_o input block handshake
//    in_data_i, in_last_i  plaintext block, last-block-of-message flag
//    out_valid_o/out_ready_i output block handshake
//    out_data_o, out_last_o ciphertext block, last-block flag
//    core_start_o, core_key_o, core_plain_text_o    request to AES core
//    core_cipher_text_i, core_ready_i, core_done_i  response from AES core
//    busy_o                high whenever the sequencer is not in IDLE
//
//  Revision    : 1.0  initial release
// ============================================================================
module aes128_cbc_seq (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_i,
    input  logic [127:0] iv_i,
    input  logic         iv_load_i,
    input  logic         in_valid_i,
    input  logic [127:0] in_data_i,
    input  logic         in_last_i,
    output logic         in_ready_o,
    output logic         out_valid_o,
    output logic [127:0] out_data_o,
    output logic         out_last_o,
    input  logic         out_ready_i,
    output logic         core_start_o,
    output logic [127:0] core_key_o,
    output logic [127:0] core_plain_text_o,
    input  logic [127:0] core_cipher_text_i,
    input  logic         core_ready_i,
    input  logic         core_done_i,
    output logic         busy_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    logic [1:0]   state_q,    state_d;
    logic [127:0] key_q,      key_d;
    logic [127:0] blk_q,      blk_d;
    logic [127:0] out_data_q, out_data_d;
    logic         last_q,     last_d;

    // Block presented to the core and effective IV-load request.
    logic [127:0] blk_in_w;
    logic         iv_load_w;

`ifdef AES_CBC_CHAIN_EN
    logic [127:0] chain_q, chain_d;
    logic [127:0] iv_q,    iv_d;

    assign blk_in_w  = in_data_i ^ chain_q;
    assign iv_load_w = iv_load_i;
`else
    // ECB: the IV inputs have no function in this build.
    logic unused_iv_w;

    assign unused_iv_w = ^{iv_i, iv_load_i};
    assign blk_in_w    = in_data_i;
    assign iv_load_w   = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            key_q      <= '0;
            blk_q      <= '0;
            out_data_q <= '0;
            last_q     <= 1'b0;
`ifdef AES_CBC_CHAIN_EN
            chain_q    <= '0;
            iv_q       <= '0;
`endif
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            blk_q      <= blk_d;
            out_data_q <= out_data_d;
            last_q     <= last_d;
`ifdef AES_CBC_CHAIN_EN
            chain_q    <= chain_d;
            iv_q       <= iv_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        blk_d      = blk_q;
        out_data_d = out_data_q;
        last_d     = last_q;
`ifdef AES_CBC_CHAIN_EN
        chain_d    = chain_q;
        iv_d       = iv_q;
`endif
        case (state_q)
            S_IDLE: begin
`ifdef AES_CBC_CHAIN_EN
                if (iv_load_i) begin
                    iv_d    = iv_i;
                    chain_d = iv_i;
                end
`endif
                // in_ready_o already excludes the IV-load cycle.
                if (in_valid_i && in_ready_o) begin
                    key_d   = key_i;
                    blk_d   = blk_in_w;
                    last_d  = in_last_i;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (core_ready_i) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // core_done_i is only meaningful here; a done left over
                // from a request abandoned by reset lands in IDLE and is
                // dropped.
                if (core_done_i) begin
                    out_data_d = core_cipher_text_i;
`ifdef AES_CBC_CHAIN_EN
                    chain_d    = core_cipher_text_i;
`endif
                    state_d    = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready_i) begin
`ifdef AES_CBC_CHAIN_EN
                    // End of message: the next block chains from the IV.
                    if (last_q) begin
                        chain_d = iv_q;
                    end
`endif
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        in_ready_o   = 1'b0;
        core_start_o = 1'b0;
        out_valid_o  = 1'b0;
        busy_o       = 1'b1;
        case (state_q)
            S_IDLE: begin
                in_ready_o = ~iv_load_w;
                busy_o     = 1'b0;
            end
            S_ISSUE: begin
                // Single-cycle pulse: the state leaves ISSUE on this edge.
                core_start_o = core_ready_i;
            end
            S_OUT: begin
                out_valid_o = 1'b1;
            end
            default: begin
                core_start_o = 1'b0;
            end
        endcase
    end

    assign out_data_o        = out_data_q;
    assign out_last_o        = last_q;
    assign core_key_o        = key_q;
    assign core_plain_text_o = blk_q;

endmodule
`default_nettype wire

// File: tb/tb_aes128_cbc_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes128_cbc_seq
//  Description : Self-checking bench for aes128_cbc_seq. Provides a
//                behavioural AES core (known-answer table plus a
//                deterministic stand-in cipher for other inputs) and a
//                scoreboard fed by directed stimulus. Honours
//                AES_CBC_CHAIN_EN the same way as the design.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_aes128_cbc_seq;

`ifdef AES_CBC_CHAIN_EN
    localparam bit CBC_ON = 1'b1;
`else
    localparam bit CBC_ON = 1'b0;
`endif

    localparam int LAT = 5;

    localparam logic [127:0] KA = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PA = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CA = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] IV = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] P2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] X1 = 128'h6bc0bce12a459991e134741a7f9e1925; // P1^IV
    localparam logic [127:0] X2 = 128'hd86421fb9f1a1eda505ee1375746972c; // P2^C1
    localparam logic [127:0] C1 = 128'h7649abac8119b246cee98e9b12e9197d;
    localparam logic [127:0] C2 = 128'h5086cb9b507219ee95db113a917678b2;
    localparam logic [127:0] E1 = 128'h3ad77bb40d7a3660a89ecaf32466ef97; // ECB(P1)
    localparam logic [127:0] E2 = 128'hf5d3d58503b9699de785895a96fdbaaf; // ECB(P2)
    localparam logic [127:0] KB = 128'hdeadbeef0123456789abcdeffedcba98;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] key_i = '0, iv_i = '0, in_data_i = '0;
    logic         iv_load_i = 1'b0, in_valid_i = 1'b0, in_last_i = 1'b0;
    logic         out_ready_i = 1'b1;
    logic         in_ready_o, out_valid_o, out_last_o, core_start_o, busy_o;
    logic [127:0] out_data_o, core_key_o, core_plain_text_o;
    logic [127:0] core_cipher_text_i = '0;
    logic         core_ready_i, core_done_i = 1'b0;

    always #5 clk = ~clk;

    aes128_cbc_seq dut (
        .clk(clk), .rst(rst), .key_i(key_i), .iv_i(iv_i), .iv_load_i(iv_load_i),
        .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_last_i(in_last_i),
        .in_ready_o(in_ready_o), .out_valid_o(out_valid_o), .out_data_o(out_data_o),
        .out_last_o(out_last_o), .out_ready_i(out_ready_i), .core_start_o(core_start_o),
        .core_key_o(core_key_o), .core_plain_text_o(core_plain_text_o),
        .core_cipher_text_i(core_cipher_text_i), .core_ready_i(core_ready_i),
        .core_done_i(core_done_i), .busy_o(busy_o)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [127:0] data;
        logic         last;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    // Bench-side reference state for chaining.
    logic [127:0] chain_m = '0;
    logic [127:0] iv_m    = '0;
    int           n_starts_exp = 0;

    // AES known answers, and a deterministic stand-in for any other input.
    function automatic logic [127:0] cipher_fn(input logic [127:0] k, input logic [127:0] p);
        if (k == KA && p == PA) return CA;
        if (k == K2 && p == X1) return C1;
        if (k == K2 && p == X2) return C2;
        if (k == K2 && p == P1) return E1;
        if (k == K2 && p == P2) return E2;
        return (p ^ {k[63:0], k[127:64]}) + 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    endfunction

    function automatic logic [127:0] model_exp(input logic [127:0] k, input logic [127:0] p);
        return cipher_fn(k, CBC_ON ? (p ^ chain_m) : p);
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural AES core
    // ------------------------------------------------------------------
    logic         core_busy = 1'b0, core_abandon = 1'b0, core_hold = 1'b0;
    logic [127:0] lat_key = '0, lat_pt = '0;
    int           core_cnt = 0, starts = 0, dones = 0, bad_starts = 0;

    assign core_ready_i = !core_busy && !core_hold;

    always @(posedge clk) begin
        core_done_i <= 1'b0;
        if (rst && core_busy) core_abandon <= 1'b1;
        if (core_busy) begin
            if (core_cnt == 0) begin
                core_done_i        <= 1'b1;
                core_cipher_text_i <= cipher_fn(lat_key, lat_pt);
                core_busy          <= 1'b0;
                core_abandon       <= 1'b0;
                dones              <= dones + 1;
            end else begin
                core_cnt <= core_cnt - 1;
            end
        end
        if (core_start_o) begin
            if (!core_ready_i) begin
                bad_starts <= bad_starts + 1;
            end else begin
                lat_key   <= core_key_o;
                lat_pt    <= core_plain_text_o;
                core_busy <= 1'b1;
                core_cnt  <= LAT - 1;
                starts    <= starts + 1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor: output scoreboard and core-input stability
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (!rst && out_valid_o && out_ready_i) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_output", {127'b0, out_valid_o}, 128'h0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("out_data", out_data_o, mon_e.data);
                chk("out_last", {127'b0, out_last_o}, {127'b0, mon_e.last});
            end
        end
        if (core_busy && !core_abandon && !rst) begin
            chk("core_key_stable", core_key_o, lat_key);
            chk("core_pt_stable", core_plain_text_o, lat_pt);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic send_block(input logic [127:0] k, input logic [127:0] p,
                              input logic lst, input logic [127:0] exp);
        int n;
        n = 0;
        key_i = k; in_data_i = p; in_last_i = lst; in_valid_i = 1'b1;
        @(negedge clk);
        while (!in_ready_o && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready_o) begin
            chk("accept_timeout", {127'b0, in_ready_o}, 128'h1);
            in_valid_i = 1'b0;
            return;
        end
        sb_q.push_back('{exp, lst});
        n_starts_exp++;
        chain_m = lst ? iv_m : exp;
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        chk("start_latency", {127'b0, core_start_o}, {127'b0, core_ready_i});
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!(sb_q.size() == 0 && !busy_o) && n < 1000);
        if (busy_o) chk("idle_timeout", {127'b0, busy_o}, 128'h0);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        logic [127:0] snap, e;
        int n, s0, d0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_in_ready",  {127'b0, in_ready_o},   128'h1);
        chk("rst_out_valid", {127'b0, out_valid_o},  128'h0);
        chk("rst_out_last",  {127'b0, out_last_o},   128'h0);
        chk("rst_core_start",{127'b0, core_start_o}, 128'h0);
        chk("rst_busy",      {127'b0, busy_o},       128'h0);
        chk("rst_out_data",  out_data_o,        128'h0);
        chk("rst_core_key",  core_key_o,        128'h0);
        chk("rst_core_pt",   core_plain_text_o, 128'h0);

        // FIPS-197 vector; IV is zero after reset in either mode.
        send_block(KA, PA, 1'b1, CA);
        wait_idle();

        // IV load together with a valid block: IV wins that cycle.
        iv_i = IV; iv_load_i = 1'b1;
        key_i = K2; in_data_i = P1; in_last_i = 1'b0; in_valid_i = 1'b1;
        #1 chk("ivload_in_ready", {127'b0, in_ready_o}, {127'b0, !CBC_ON});
        @(posedge clk); #1;
        iv_load_i = 1'b0;
        chk("ivload_not_accepted", {127'b0, busy_o}, {127'b0, !CBC_ON});
        if (CBC_ON) begin
            iv_m = IV; chain_m = IV;
            send_block(K2, P1, 1'b0, C1);
        end else begin
            sb_q.push_back('{E1, 1'b0});
            n_starts_exp++;
            in_valid_i = 1'b0;
        end
        send_block(K2, P2, 1'b1, CBC_ON ? C2 : E2);
        // Message restart: both restart from the IV.
        send_block(K2, P1, 1'b1, CBC_ON ? C1 : E1);
        send_block(K2, P1, 1'b1, CBC_ON ? C1 : E1);
        wait_idle();

        // ISSUE hold while the core is not ready, then output backpressure.
        out_ready_i = 1'b0;
        core_hold   = 1'b1;
        e = model_exp(KB, 128'h11111111222222223333333344444444);
        send_block(KB, 128'h11111111222222223333333344444444, 1'b0, e);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("issue_hold_start", {127'b0, core_start_o}, 128'h0);
            chk("issue_hold_busy",  {127'b0, busy_o},       128'h1);
        end
        @(posedge clk); #1 core_hold = 1'b0;
        n = 0;
        @(negedge clk);
        while (!out_valid_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bp_out_valid_seen", {127'b0, out_valid_o}, 128'h1);
        snap = out_data_o;
        s0   = starts;
        @(posedge clk); #1;
        iv_i = 128'hffffeeeeddddccccbbbbaaaa99998888; iv_load_i = 1'b1;
        key_i = KB; in_data_i = 128'h5555; in_last_i = 1'b0; in_valid_i = 1'b1;
        @(posedge clk); #1 iv_load_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp_data_stable", out_data_o, snap);
            chk("bp_in_ready",    {127'b0, in_ready_o},  128'h0);
            chk("bp_out_valid",   {127'b0, out_valid_o}, 128'h1);
        end
        chk("bp_no_start", starts, s0);
        @(posedge clk); #1;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        e = model_exp(KB, 128'h99998888777766665555444433332222);
        send_block(KB, 128'h99998888777766665555444433332222, 1'b1, e);
        wait_idle();

        // Reset while waiting on the core; its late done must be dropped.
        key_i = KB; in_data_i = 128'hcafef00d; in_last_i = 1'b0; in_valid_i = 1'b1;
        @(posedge clk); #1 in_valid_i = 1'b0;
        n_starts_exp++;
        s0 = starts; d0 = dones; n = 0;
        while (starts == s0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rw_core_started", starts, s0 + 1);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chain_m = '0; iv_m = '0;
        n = 0;
        while (dones == d0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rw_core_done_seen", dones, d0 + 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rw_out_valid", {127'b0, out_valid_o}, 128'h0);
            chk("rw_in_ready",  {127'b0, in_ready_o},  128'h1);
            chk("rw_busy",      {127'b0, busy_o},      128'h0);
        end
        chk("rw_out_data", out_data_o, 128'h0);
        chk("rw_core_key", core_key_o, 128'h0);
        @(posedge clk); #1;

        // Recovery after reset: chain restarted from zero.
        e = model_exp(KB, 128'h0123456789abcdef0011223344556677);
        send_block(KB, 128'h0123456789abcdef0011223344556677, 1'b0, e);
        e = model_exp(KA, 128'hfedcba98765432100f0e0d0c0b0a0908);
        send_block(KA, 128'hfedcba98765432100f0e0d0c0b0a0908, 1'b1, e);
        send_block(KA, PA, 1'b1, CA);
        wait_idle();

        chk("sb_empty",    sb_q.size(), 0);
        chk("bad_starts",  bad_starts, 0);
        chk("start_count", starts, n_starts_exp);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/aes128_cbc_seq.md
AES128_CBC_SEQ -- requirements
Module: aes128_cbc_seq

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all logic on rising edge.
REQ-002 SHALL have port: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have port: key_i  in  128  cipher key, sampled on input acceptance.
REQ-004 SHALL have port: iv_i  in  128  initialisation vector, sampled when iv_load_i=1 in IDLE.
REQ-005 SHALL have port: iv_load_i  in  1  single-cycle pulse that loads iv_i into the chain register.
REQ-006 SHALL have ports: in_valid_i  in  1; in_data_i  in  128; in_last_i  in  1 (last block of message); in_ready_o  out  1.
REQ-007 SHALL have ports: out_valid_o  out  1; out_data_o  out  128 (ciphertext); out_last_o  out  1; out_ready_i  in  1.
REQ-008 SHALL have ports: core_start_o  out  1; core_key_o  out  128; core_plain_text_o  out  128.
REQ-009 SHALL have ports: core_cipher_text_i  in  128; core_ready_i  in  1; core_done_i  in  1. These connect to the existing AES-128 core.
REQ-010 SHALL have port: busy_o  out  1, high in any state other than IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, ISSUE, WAIT, OUT, with exactly one block in flight.
REQ-012 IDLE: in_ready_o=1. On in_valid_i&in_ready_o: latch key_i, latch in_data_i XOR chain (plain data if CBC disabled), latch in_last_i, and go to ISSUE.
REQ-013 ISSUE: when core_ready_i=1, assert core_start_o for exactly one cycle and go to WAIT. Otherwise hold, with core_start_o=0.
REQ-014 core_key_o and core_plain_text_o SHALL stay stable from ISSUE entry until core_done_i is observed.
REQ-015 WAIT: on core_done_i=1, latch core_cipher_text_i into the output register and the chain register, then go to OUT. core_done_i SHALL be ignored in all other states.
REQ-016 OUT: out_valid_o=1, and out_data_o/out_last_o SHALL stay stable until out_ready_i=1. On that handshake, return to IDLE.
REQ-017 If the accepted block had in_last_i=1, the chain register SHALL reload from the stored IV on the OUT handshake, so the next message restarts chaining.
REQ-018 iv_load_i SHALL take effect only in IDLE, and SHALL take priority over a simultaneous input acceptance: that cycle loads the IV and in_ready_o=0. iv_load_i SHALL be ignored outside IDLE.
REQ-019 Latency: accept edge to core_start_o = 1 cycle minimum. core_done_i edge to out_valid_o = 1 cycle.
REQ-020 Throughput SHALL be one block per (core latency + 3) cycles when out_ready_i is held high.
REQ-021 in_ready_o SHALL be 0 in ISSUE, WAIT and OUT. No input is buffered while busy.

Reset
REQ-022 rst SHALL force IDLE on the next edge from any state, including mid-WAIT.
REQ-023 After reset: in_ready_o=1, out_valid_o=0, out_last_o=0, core_start_o=0, busy_o=0.
REQ-024 After reset, out_data_o, core_key_o, core_plain_text_o, the chain register and the stored IV SHALL all be 128'h0.
REQ-025 A core_done_i arriving after a mid-operation reset SHALL be ignored.

Configuration
REQ-026 Macro AES_CBC_CHAIN_EN defined: CBC mode per REQ-012/015/017.
REQ-027 Macro AES_CBC_CHAIN_EN undefined: ECB mode. No XOR is applied, and the chain and IV registers are not instantiated.
REQ-028 Without AES_CBC_CHAIN_EN, iv_i and iv_load_i SHALL be ignored; all other timing is identical.

Verification
REQ-029 ECB/CBC, IV=0: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> out_data_o 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-030 CBC (macro on): key 2b7e151628aed2a6abf7158809cf4f3c, IV 000102030405060708090a0b0c0d0e0f, P1 6bc1bee22e409f96e93d7e117393172a, P2 ae2d8a571e03ac9c9eb76fac45af8e51 -> C1 7649abac8119b246cee98e9b12e9197d, C2 5086cb9b507219ee95db113a917678b2.
REQ-031 Backpressure: hold out_ready_i=0 for 20 cycles after out_valid_o -> out_data_o stable, in_ready_o=0, no further core_start_o.
REQ-032 Message restart: send P1 with in_last_i=1, then P1 again -> both outputs equal C1 (7649abac...).
REQ-033 Reset mid-WAIT: pulse rst, then core_done_i arrives -> out_valid_o stays 0 and in_ready_o=1.
REQ-034 Simultaneous iv_load_i and in_valid_i in IDLE -> IV loaded, block not accepted until the next cycle.
